image_sequencer: RTL and testbench

- Frame-level scheduler that drives image_transmit_fsm.
- Launches a programmed number of image acquisitions (frames) at a fixed start-to-start period.
- Handshakes on the transmit FSM's busy and transmit_in_progress outputs and guards each frame with a watchdog.
- Sits between the host command decode and image_transmit_fsm; owns that FSM's start_transmit input.

---
 rtl/image_sequencer.sv | 170 +++++++++++++++++
 tb/tb_image_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_sequencer.sv
// Frame-level scheduler for image_transmit_fsm: launches a programmed number of frames at a
// fixed start-to-start period, handshaking on busy/in_progress and watchdogging each frame.
module image_sequencer #(
    parameter int PERIOD_W    = 32,
    parameter int FRAME_W     = 16,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic [FRAME_W-1:0]  frame_count,
    input  logic [PERIOD_W-1:0] frame_period,
    input  logic                xmit_busy,
    input  logic                xmit_in_progress,
    output logic                start_transmit,
    output logic                seq_active,
    output logic [FRAME_W-1:0]  frames_done,
    output logic                seq_done,
    output logic                overrun,
    output logic                timeout_err,
    output logic [2:0]          state_dbg
);

    localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_REQ  = 3'd2,
        S_RUN  = 3'd3,
        S_WAIT = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t              state, state_nxt;
    logic [FRAME_W-1:0]  frames_lat;
    logic [PERIOD_W-1:0] period_lat;
    logic [PERIOD_W-1:0] period_cnt;
    logic [WDOG_W-1:0]   wdog;
    logic                stop_pend;

    logic accept, arm_go, run_go, frame_end, set_ovr, set_err, done_set, last_frame;
    logic [PERIOD_W-1:0] period_clamp;

    assign period_clamp = (frame_period < PERIOD_W'(4)) ? PERIOD_W'(4) : frame_period;
    assign last_frame   = (frames_lat != '0) && ((frames_done + FRAME_W'(1)) == frames_lat);

    // Handshake: start_transmit is held from REQ entry until xmit_in_progress is seen high;
    // the transmit FSM samples it on negedge, so dropping it earlier could lose the request.
    assign start_transmit = (state == S_REQ);
    assign seq_active     = (state != S_IDLE);
    assign state_dbg      = state;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        arm_go    = 1'b0;
        run_go    = 1'b0;
        frame_end = 1'b0;
        set_ovr   = 1'b0;
        set_err   = 1'b0;
        done_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    state_nxt = S_ARM;
                    accept    = 1'b1;
                end
            end
            S_ARM: begin
                if (stop_pend || cmd_stop) begin
                    state_nxt = S_IDLE;
                    done_set  = 1'b1;
                end else if (!xmit_busy && !xmit_in_progress) begin
                    state_nxt = S_REQ;
                    arm_go    = 1'b1;
                end
            end
            S_REQ: begin
                if (xmit_in_progress) begin
                    state_nxt = S_RUN;
                    run_go    = 1'b1;
                end else if (wdog == WDOG_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_RUN: begin
                if (!xmit_in_progress) begin
                    frame_end = 1'b1;
                    if (last_frame || stop_pend) begin
                        state_nxt = S_IDLE;
                        done_set  = 1'b1;
                    end else if (period_cnt >= period_lat) begin
                        state_nxt = S_ARM;
                        set_ovr   = 1'b1;
                    end else if (period_cnt == period_lat - PERIOD_W'(1)) begin
                        // Period expires on this very edge: re-arm now so the spacing stays exact.
                        state_nxt = S_ARM;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else if (wdog == WDOG_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_WAIT: begin
                if (stop_pend || cmd_stop) begin
                    state_nxt = S_IDLE;
                    done_set  = 1'b1;
                end else if (period_cnt >= period_lat - PERIOD_W'(1)) begin
                    state_nxt = S_ARM;
                end
            end
            S_ERR: begin
                state_nxt = S_IDLE;
                set_err   = 1'b1;
                done_set  = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            frames_lat  <= '0;
            period_lat  <= '0;
            period_cnt  <= '0;
            wdog        <= '0;
            stop_pend   <= 1'b0;
            frames_done <= '0;
            seq_done    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            seq_done <= done_set;
            if (accept) begin
                frames_lat  <= frame_count;
                period_lat  <= period_clamp;
                frames_done <= '0;
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
                stop_pend   <= 1'b0;
            end else if (cmd_stop && (state == S_REQ || state == S_RUN)) begin
                stop_pend <= 1'b1;
            end
            if (frame_end && frames_done != '1)
                frames_done <= frames_done + FRAME_W'(1);
            if (set_ovr)
                overrun <= 1'b1;
            if (set_err)
                timeout_err <= 1'b1;
            // Not cleared in ARM, so a busy-stalled ARM eats into the period instead of extending it.
            if (arm_go)
                period_cnt <= PERIOD_W'(1);
            else if (state == S_IDLE)
                period_cnt <= '0;
            else if (period_cnt != '1)
                period_cnt <= period_cnt + PERIOD_W'(1);
            if (arm_go || run_go)
                wdog <= '0;
            else if ((state == S_REQ || state == S_RUN) && wdog != WDOG_LAST)
                wdog <= wdog + WDOG_W'(1);
        end
    end

endmodule

// File: tb/tb_image_sequencer.sv
// Bench for image_sequencer: a behavioural transmit-FSM model drives busy/in_progress, and
// start_transmit rise/fall times are scored against arithmetic predictions of the frame timing.
module tb_image_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic [15:0] frame_count = '0;
    logic [31:0] frame_period = '0;
    logic        xmit_busy;
    logic        xmit_in_progress = 1'b0;
    logic        start_transmit, seq_active, seq_done, overrun, timeout_err;
    logic [15:0] frames_done;
    logic [2:0]  state_dbg;

    logic force_busy = 1'b0;
    logic m_busy = 1'b0;
    assign xmit_busy = m_busy | force_busy;

    image_sequencer #(.PERIOD_W(32), .FRAME_W(16), .WDOG_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .frame_count(frame_count), .frame_period(frame_period),
        .xmit_busy(xmit_busy), .xmit_in_progress(xmit_in_progress),
        .start_transmit(start_transmit), .seq_active(seq_active),
        .frames_done(frames_done), .seq_done(seq_done), .overrun(overrun),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    // clock / cycle counter
    initial forever #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // transmit FSM model and monitor, both on negedge
    int m_d = 2;
    int m_l = 10;
    int mcnt = 0;
    bit m_act = 0;
    bit prev_st = 0;
    int done_cnt = 0;
    int rise_q[$];
    int fall_q[$];

    always @(negedge clk) begin
        if (start_transmit && !prev_st) rise_q.push_back(cyc);
        if (!start_transmit && prev_st) fall_q.push_back(cyc);
        prev_st = start_transmit;
        if (seq_done) done_cnt++;
        if (!m_act) begin
            if (start_transmit) begin
                m_act = 1; mcnt = 0; m_busy = 1'b1;
            end
        end else begin
            mcnt++;
            if (!xmit_in_progress && !start_transmit) begin
                m_act = 0; m_busy = 1'b0;
            end else if (mcnt == m_d) begin
                xmit_in_progress = 1'b1;
            end else if (mcnt == m_d + m_l) begin
                xmit_in_progress = 1'b0; m_busy = 1'b0; m_act = 0;
            end
        end
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: start is seen at negedge r, in_progress spans negedges r+d..r+d+l, so the
    // sequencer first sees it low d+l+1 edges after the rise and can re-request one edge later.
    function automatic void ref_model(input int frames, input int p, input int d, input int l,
                                      output int space, output bit ovr);
        int pc;
        int end_edge;
        pc = (p < 4) ? 4 : p;
        end_edge = d + l + 1;
        space = (pc > end_edge + 1) ? pc : end_edge + 1;
        ovr = (frames > 1) && (end_edge >= pc);
    endfunction

    task automatic run_seq(input string name, input int n, input int p, input int d, input int l,
                           input int stop_at, input bit busy_hold, input int exp_frames,
                           input int exp_space, input bit exp_ovr);
        int k, r0, f0, d0, first, n_r, budget;
        bit got;
        logic [31:0] e;
        m_d = d; m_l = l;
        frame_count = 16'(n);
        frame_period = 32'(p);
        r0 = rise_q.size(); f0 = fall_q.size(); d0 = done_cnt;
        @(negedge clk);
        cmd_start = 1'b1; force_busy = busy_hold; k = cyc;
        @(negedge clk);
        cmd_start = 1'b0;
        if (busy_hold) begin
            repeat (29) @(negedge clk);
            force_busy = 1'b0;
        end
        first = k + 2 + (busy_hold ? 29 : 0);
        if (stop_at > 0) begin
            got = 0;
            for (int i = 0; i < stop_at * exp_space + 200 && !got; i++) begin
                @(negedge clk);
                if (rise_q.size() - r0 >= stop_at && xmit_in_progress) got = 1;
            end
            check({name, "_stop_reached"}, 32'(got), 1);
            cmd_stop = 1'b1;
            @(negedge clk);
            cmd_stop = 1'b0;
        end
        budget = exp_frames * exp_space + 300;
        got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done_cnt != d0) got = 1;
        end
        check({name, "_seq_done_seen"}, 32'(got), 1);
        repeat (exp_space + 20) @(negedge clk);
        n_r = rise_q.size() - r0;
        check({name, "_rise_count"}, 32'(n_r), 32'(exp_frames));
        for (int i = 0; i < exp_frames; i++) exp_q.push_back(32'(first + i * exp_space));
        for (int i = 0; i < exp_frames; i++) begin
            e = exp_q.pop_front();
            if (i < n_r) begin
                check($sformatf("%s_rise%0d", name, i), 32'(rise_q[r0 + i]), e);
                if (f0 + i < fall_q.size())
                    check($sformatf("%s_hold%0d", name, i),
                          32'(fall_q[f0 + i] - rise_q[r0 + i]), 32'(d + 1));
            end
        end
        check({name, "_frames_done"}, 32'(frames_done), 32'(exp_frames));
        check({name, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        check({name, "_timeout_err"}, 32'(timeout_err), 0);
        check({name, "_seq_done_pulses"}, 32'(done_cnt - d0), 1);
        check({name, "_seq_active"}, 32'(seq_active), 0);
    endtask

    typedef struct {
        string name;
        int    n;
        int    p;
        int    d;
        int    l;
        int    stop_at;
        bit    busy;
        int    exp_frames;
        int    exp_space;
        bit    exp_ovr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k, r0, f0, d0, sp, rn, rp, rd, rl;
        bit ov, got, act_seen;

        vecs[0] = '{"three_frames", 3, 200, 2, 50, 0, 1'b0, 3, 200, 1'b0};
        vecs[1] = '{"overrun",      2,  40, 2, 60, 0, 1'b0, 2,  64, 1'b1};
        vecs[2] = '{"cont_stop",    0, 100, 2, 50, 5, 1'b0, 5, 100, 1'b0};
        vecs[3] = '{"busy_hold",    1,  50, 3, 20, 0, 1'b1, 1,  50, 1'b0};
        vecs[4] = '{"clamp_exact",  2,   2, 1,  1, 0, 1'b0, 2,   4, 1'b0};
        vecs[5] = '{"clamp_ovr",    2,   3, 1,  2, 0, 1'b0, 2,   5, 1'b1};
        vecs[6] = '{"short_wait",   3,  10, 1,  5, 0, 1'b0, 3,  10, 1'b0};

        // reset
        repeat (3) @(negedge clk);
        check("rst_start_transmit", 32'(start_transmit), 0);
        check("rst_seq_active", 32'(seq_active), 0);
        check("rst_frames_done", 32'(frames_done), 0);
        check("rst_flags", 32'({seq_done, overrun, timeout_err}), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_seq(vecs[i].name, vecs[i].n, vecs[i].p, vecs[i].d, vecs[i].l, vecs[i].stop_at,
                    vecs[i].busy, vecs[i].exp_frames, vecs[i].exp_space, vecs[i].exp_ovr);

        // watchdog: in_progress never rises
        m_d = 1000; m_l = 5;
        frame_count = 16'd1; frame_period = 32'd200;
        r0 = rise_q.size(); f0 = fall_q.size(); d0 = done_cnt;
        @(negedge clk);
        cmd_start = 1'b1; k = cyc;
        @(negedge clk);
        cmd_start = 1'b0;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done_cnt != d0) got = 1;
        end
        check("wdog_seq_done_seen", 32'(got), 1);
        repeat (5) @(negedge clk);
        check("wdog_rise_count", 32'(rise_q.size() - r0), 1);
        if (rise_q.size() > r0 && fall_q.size() > f0) begin
            check("wdog_rise", 32'(rise_q[r0]), 32'(k + 2));
            check("wdog_start_len", 32'(fall_q[f0] - rise_q[r0]), 64);
        end
        check("wdog_timeout_err", 32'(timeout_err), 1);
        check("wdog_frames_done", 32'(frames_done), 0);
        check("wdog_seq_done_pulses", 32'(done_cnt - d0), 1);
        check("wdog_overrun", 32'(overrun), 0);

        // start and stop together: stop wins, nothing happens
        m_d = 2; m_l = 10;
        r0 = rise_q.size(); d0 = done_cnt; act_seen = 0;
        @(negedge clk);
        cmd_start = 1'b1; cmd_stop = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_stop = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (seq_active) act_seen = 1;
        end
        check("startstop_active", 32'(act_seen), 0);
        check("startstop_rises", 32'(rise_q.size() - r0), 0);
        check("startstop_done", 32'(done_cnt - d0), 0);
        check("startstop_timeout_kept", 32'(timeout_err), 1);

        // asynchronous reset in the middle of frame 2
        m_d = 2; m_l = 30;
        frame_count = 16'd0; frame_period = 32'd50;
        r0 = rise_q.size();
        @(negedge clk);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (rise_q.size() - r0 >= 2 && xmit_in_progress) got = 1;
        end
        check("arst_reached_frame2", 32'(got), 1);
        repeat (5) @(negedge clk);
        check("arst_pre_frames_done", 32'(frames_done), 1);
        d0 = done_cnt;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("arst_start_transmit", 32'(start_transmit), 0);
        check("arst_seq_active", 32'(seq_active), 0);
        check("arst_frames_done", 32'(frames_done), 0);
        check("arst_flags", 32'({seq_done, overrun, timeout_err}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!xmit_busy && !xmit_in_progress) got = 1;
        end
        check("arst_model_idle", 32'(got), 1);
        check("arst_no_seq_done", 32'(done_cnt - d0), 0);
        run_seq("post_reset", 2, 60, 2, 20, 0, 1'b0, 2, 60, 1'b0);

        // randomized sequences against the reference model
        for (int i = 0; i < 8; i++) begin
            rn = $urandom_range(1, 4);
            rp = $urandom_range(0, 80);
            rd = $urandom_range(1, 4);
            rl = $urandom_range(1, 40);
            ref_model(rn, rp, rd, rl, sp, ov);
            run_seq($sformatf("rand%0d_n%0d_p%0d_d%0d_l%0d", i, rn, rp, rd, rl),
                    rn, rp, rd, rl, 0, 1'b0, rn, sp, ov);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
